// File: rtl/fp_divsqrt_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_divsqrt_issue_ctrl
// Purpose  : Request FIFO, single-op issue FSM and held response register in
//            front of the non-stalling iterative FP div/sqrt unit.
// Options  : FP_DIVSQRT_PERF_CNT_EN adds perf_ops_o / perf_stall_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module fp_divsqrt_issue_ctrl #(
  parameter int FP_WIDTH   = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [FP_WIDTH-1:0]   req_opa_i,
  input  logic [FP_WIDTH-1:0]   req_opb_i,
  input  logic                  req_sqrt_i,
  input  logic [RND_WIDTH-1:0]  req_rnd_i,
  input  logic [TAG_WIDTH-1:0]  req_tag_i,
  output logic                  en_o,
  output logic [FP_WIDTH-1:0]   opa_o,
  output logic [FP_WIDTH-1:0]   opb_o,
  output logic                  sqrt_sel_o,
  output logic [RND_WIDTH-1:0]  rnd_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  input  logic                  unit_ready_i,
  input  logic                  unit_valid_i,
  input  logic [FP_WIDTH-1:0]   unit_res_i,
  input  logic [STAT_WIDTH-1:0] unit_status_i,
  input  logic [TAG_WIDTH-1:0]  unit_tag_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [FP_WIDTH-1:0]   rsp_res_o,
  output logic [STAT_WIDTH-1:0] rsp_status_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
`ifdef FP_DIVSQRT_PERF_CNT_EN
  output logic [31:0]           perf_ops_o,
  output logic [31:0]           perf_stall_o,
`endif
  output logic                  busy_o
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_PTR_ONE = 1;

  typedef struct packed {
    logic [FP_WIDTH-1:0]  opa;
    logic [FP_WIDTH-1:0]  opb;
    logic                 sqrt;
    logic [RND_WIDTH-1:0] rnd;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  req_t                  r_mem [DEPTH];
  logic [c_ADDR_W:0]     r_wr_ptr;
  logic [c_ADDR_W:0]     r_rd_ptr;
  state_t                r_state;
  logic                  r_rsp_valid;
  logic [FP_WIDTH-1:0]   r_rsp_res;
  logic [STAT_WIDTH-1:0] r_rsp_status;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_slot_free;
  logic w_issue;
  logic w_capture;
  req_t w_head;
  req_t w_push_entry;

  // Full when the indices match but the wrap bits differ.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign w_push  = req_valid_i & ~w_full;

  // Issuing only when the response slot is free (or draining now) means a
  // done pulse always has somewhere to land.
  assign w_slot_free = ~r_rsp_valid | rsp_ready_i;
  assign w_issue     = (r_state == ST_IDLE) & ~w_empty & unit_ready_i & w_slot_free;
  assign w_capture   = (r_state == ST_WAIT) & unit_valid_i;

  assign w_push_entry = '{opa: req_opa_i, opb: req_opb_i, sqrt: req_sqrt_i,
                          rnd: req_rnd_i, tag: req_tag_i};
  assign w_head       = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= w_push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_rsp_valid  <= 1'b0;
      r_rsp_res    <= '0;
      r_rsp_status <= '0;
      r_rsp_tag    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (unit_valid_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_res    <= unit_res_i;
        r_rsp_status <= unit_status_i;
        r_rsp_tag    <= unit_tag_i;
      end else if (r_rsp_valid && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FP_DIVSQRT_PERF_CNT_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_capture) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
      if ((r_state == ST_IDLE) && !w_empty && !w_issue) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_ops_o   = r_perf_ops;
  assign perf_stall_o = r_perf_stall;
`endif

  assign req_ready_o  = ~w_full;
  assign en_o         = w_issue;
  assign opa_o        = w_head.opa;
  assign opb_o        = w_head.opb;
  assign sqrt_sel_o   = w_head.sqrt;
  assign rnd_o        = w_head.rnd;
  assign tag_o        = w_head.tag;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_res_o    = r_rsp_res;
  assign rsp_status_o = r_rsp_status;
  assign rsp_tag_o    = r_rsp_tag;
  assign busy_o       = ~w_empty | (r_state == ST_WAIT) | r_rsp_valid;

endmodule
`default_nettype wire
